// File: rtl/reg_read_stage_pkg.sv
// Shared definitions for the decode-stage register read slice.
//   - Default widths/sizes for the register file and operand datapath.
//   - Register-number constants R0..R7.
//   - Pipeline-register action type and the priority decode that picks it.
package reg_read_stage_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_REG_N    = 8;
    localparam int DEF_ADDR_W   = 3;
    localparam bit DEF_ZERO_REG = 1'b0;

    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4;
    localparam logic [2:0] R5 = 3'd5;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

    // What the decode/execute pipeline register does on the next edge.
    typedef enum logic [1:0] {
        PR_FLUSH,   // kill the held/captured instruction, keep data
        PR_STALL,   // hold, but refresh operands from write-back
        PR_LOAD,    // capture a new instruction
        PR_IDLE     // bubble: drop valid, keep data
    } pr_action_e;

    // Flush beats stall, stall beats a new instruction.
    function automatic pr_action_e pr_action(input logic flush,
                                             input logic stall,
                                             input logic in_valid);
        if (flush)    return PR_FLUSH;
        if (stall)    return PR_STALL;
        if (in_valid) return PR_LOAD;
        return PR_IDLE;
    endfunction

endpackage

// File: rtl/reg_read_stage_if.sv
// Decode-stage register read bus.
//   master : decode / write-back / hazard side (drives instruction, stall,
//            flush and write-back port; receives the pipeline register)
//   slave  : reg_read_stage itself
interface reg_read_stage_if
    import reg_read_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              in_valid;
    logic [ADDR_W-1:0] n_rs_in;
    logic [ADDR_W-1:0] n_rt_in;
    logic [ADDR_W-1:0] n_rd_in;
    logic              stall;
    logic              flush;
    logic              wb_en;
    logic [ADDR_W-1:0] n_wb;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic [DATA_W-1:0] rs_out;
    logic [DATA_W-1:0] rt_out;
    logic [ADDR_W-1:0] n_rs_out;
    logic [ADDR_W-1:0] n_rt_out;
    logic [ADDR_W-1:0] n_rd_out;

    modport master (
        output in_valid, n_rs_in, n_rt_in, n_rd_in, stall, flush,
               wb_en, n_wb, wb_data,
        input  out_valid, rs_out, rt_out, n_rs_out, n_rt_out, n_rd_out
    );

    modport slave (
        input  in_valid, n_rs_in, n_rt_in, n_rd_in, stall, flush,
               wb_en, n_wb, wb_data,
        output out_valid, rs_out, rt_out, n_rs_out, n_rt_out, n_rd_out
    );
endinterface

// File: rtl/reg_read_stage_regfile_mem.sv
// Architectural register file: REG_N x DATA_W flops, async reset,
// one write port and two combinational read ports.
//   clk_dc, rst      : clock, async active-high reset (clears every entry)
//   wb_en/n_wb/wb_data : write port; out-of-range numbers and (when
//                      ZERO_REG) register 0 are never written
//   n_ra/ra_data, n_rb/rb_data : read ports; out-of-range numbers read 0
module reg_read_stage_regfile_mem
    import reg_read_stage_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_N    = DEF_REG_N,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = DEF_ZERO_REG
) (
    input  logic              clk_dc,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] n_wb,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] n_ra,
    input  logic [ADDR_W-1:0] n_rb,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data
);

    localparam logic [ADDR_W:0] REG_N_W = (ADDR_W + 1)'(REG_N);

    logic [DATA_W-1:0] regs_reg [REG_N];
    logic [REG_N-1:0]  wr_sel;

    // One-hot write decode; a hard-wired zero register never decodes.
    // Numbers >= REG_N match no entry, so those writes fall away.
    for (genvar gi = 0; gi < REG_N; gi++) begin : g_wsel
        if (ZERO_REG && gi == 0) begin : g_ro
            assign wr_sel[gi] = 1'b0;
        end else begin : g_rw
            assign wr_sel[gi] = wb_en && (n_wb == ADDR_W'(gi));
        end
    end

    // Async reset rules out block RAM here; this is a flop array.
    always_ff @(posedge clk_dc or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_N; i++) begin
                if (wr_sel[i]) begin
                    regs_reg[i] <= wb_data;
                end
            end
        end
    end

    assign ra_data = ({1'b0, n_ra} < REG_N_W) ? regs_reg[n_ra] : '0;
    assign rb_data = ({1'b0, n_rb} < REG_N_W) ? regs_reg[n_rb] : '0;

endmodule

// File: rtl/reg_read_stage.sv
// Decode-stage register read.
// Owns the register file, selects operands with write-to-read bypass and
// registers them, together with the register numbers, into the
// decode/execute pipeline register. While stalled, held operands are
// refreshed from write-back so the instruction never leaves with stale data.
//   clk_dc : stage clock (rising edge)
//   rst    : async active-high reset
//   bus    : reg_read_stage_if.slave (instruction in, stall/flush,
//            write-back port, pipeline register out)
module reg_read_stage
    import reg_read_stage_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_N    = DEF_REG_N,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = DEF_ZERO_REG
) (
    input  logic          clk_dc,
    input  logic          rst,
    reg_read_stage_if.slave bus
);

    localparam logic [ADDR_W:0] REG_N_W = (ADDR_W + 1)'(REG_N);

    logic [DATA_W-1:0] ra_data, rb_data;
    logic [DATA_W-1:0] rs_sel, rt_sel;
    logic [DATA_W-1:0] rs_refresh, rt_refresh;
    logic              rs_hit, rt_hit;
    pr_action_e        action;

    logic              valid_reg;
    logic [DATA_W-1:0] rs_reg, rt_reg;
    logic [ADDR_W-1:0] n_rs_reg, n_rt_reg, n_rd_reg;

    reg_read_stage_regfile_mem #(
        .DATA_W   (DATA_W),
        .REG_N    (REG_N),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_regfile (
        .clk_dc  (clk_dc),
        .rst     (rst),
        .wb_en   (bus.wb_en),
        .n_wb    (bus.n_wb),
        .wb_data (bus.wb_data),
        .n_ra    (bus.n_rs_in),
        .n_rb    (bus.n_rt_in),
        .ra_data (ra_data),
        .rb_data (rb_data)
    );

    // A register number that can hold a non-zero value.
    function automatic logic readable(input logic [ADDR_W-1:0] n);
        return ({1'b0, n} < REG_N_W) && !(ZERO_REG && n == '0);
    endfunction

    // Operand select: forced zero, then same-cycle write bypass, then storage.
    function automatic logic [DATA_W-1:0] operand(input logic [ADDR_W-1:0] n,
                                                  input logic [DATA_W-1:0] stored,
                                                  input logic              wen,
                                                  input logic [ADDR_W-1:0] nwb,
                                                  input logic [DATA_W-1:0] wdata);
        if (!readable(n))        return '0;
        if (wen && nwb == n)     return wdata;
        return stored;
    endfunction

    assign rs_sel = operand(bus.n_rs_in, ra_data, bus.wb_en, bus.n_wb, bus.wb_data);
    assign rt_sel = operand(bus.n_rt_in, rb_data, bus.wb_en, bus.n_wb, bus.wb_data);

    // Stall refresh: only a live held instruction picks up write-back data,
    // and the forced-zero rule still overrides it.
    assign rs_hit     = valid_reg && bus.wb_en && (bus.n_wb == n_rs_reg);
    assign rt_hit     = valid_reg && bus.wb_en && (bus.n_wb == n_rt_reg);
    assign rs_refresh = readable(n_rs_reg) ? bus.wb_data : '0;
    assign rt_refresh = readable(n_rt_reg) ? bus.wb_data : '0;

    assign action = pr_action(bus.flush, bus.stall, bus.in_valid);

    always_ff @(posedge clk_dc or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            rs_reg    <= '0;
            rt_reg    <= '0;
            n_rs_reg  <= '0;
            n_rt_reg  <= '0;
            n_rd_reg  <= '0;
        end else begin
            case (action)
                PR_FLUSH: begin
                    valid_reg <= 1'b0;
                end
                PR_STALL: begin
                    if (rs_hit) rs_reg <= rs_refresh;
                    if (rt_hit) rt_reg <= rt_refresh;
                end
                PR_LOAD: begin
                    valid_reg <= 1'b1;
                    rs_reg    <= rs_sel;
                    rt_reg    <= rt_sel;
                    n_rs_reg  <= bus.n_rs_in;
                    n_rt_reg  <= bus.n_rt_in;
                    n_rd_reg  <= bus.n_rd_in;
                end
                default: begin
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = valid_reg;
    assign bus.rs_out    = rs_reg;
    assign bus.rt_out    = rt_reg;
    assign bus.n_rs_out  = n_rs_reg;
    assign bus.n_rt_out  = n_rt_reg;
    assign bus.n_rd_out  = n_rd_reg;

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage. Two instances share one stimulus stream:
//   dut_a : REG_N=8, ZERO_REG=0
//   dut_b : REG_N=6, ZERO_REG=1
// A cycle-level reference model predicts each instance's pipeline register;
// predictions are queued when inputs are driven and popped after the edge.
module tb_reg_read_stage;
    import reg_read_stage_pkg::*;

    logic        clk_dc = 1'b0;
    logic        rst    = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  n_rs_in = '0, n_rt_in = '0, n_rd_in = '0;
    logic        stall = 1'b0, flush = 1'b0, wb_en = 1'b0;
    logic [2:0]  n_wb = '0;
    logic [15:0] wb_data = '0;

    always #5 clk_dc = ~clk_dc;

    reg_read_stage_if #(.DATA_W(16), .ADDR_W(3)) bus_a ();
    reg_read_stage_if #(.DATA_W(16), .ADDR_W(3)) bus_b ();

    assign bus_a.in_valid = in_valid;  assign bus_b.in_valid = in_valid;
    assign bus_a.n_rs_in  = n_rs_in;   assign bus_b.n_rs_in  = n_rs_in;
    assign bus_a.n_rt_in  = n_rt_in;   assign bus_b.n_rt_in  = n_rt_in;
    assign bus_a.n_rd_in  = n_rd_in;   assign bus_b.n_rd_in  = n_rd_in;
    assign bus_a.stall    = stall;     assign bus_b.stall    = stall;
    assign bus_a.flush    = flush;     assign bus_b.flush    = flush;
    assign bus_a.wb_en    = wb_en;     assign bus_b.wb_en    = wb_en;
    assign bus_a.n_wb     = n_wb;      assign bus_b.n_wb     = n_wb;
    assign bus_a.wb_data  = wb_data;   assign bus_b.wb_data  = wb_data;

    reg_read_stage #(.DATA_W(16), .REG_N(8), .ADDR_W(3), .ZERO_REG(1'b0)) dut_a (
        .clk_dc (clk_dc), .rst (rst), .bus (bus_a)
    );
    reg_read_stage #(.DATA_W(16), .REG_N(6), .ADDR_W(3), .ZERO_REG(1'b1)) dut_b (
        .clk_dc (clk_dc), .rst (rst), .bus (bus_b)
    );

    typedef struct {
        int          dut;
        logic        valid;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [2:0]  nrs;
        logic [2:0]  nrt;
        logic [2:0]  nrd;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mout [2];
    logic [15:0] mregs [2][8];
    int          m_regn [2] = '{8, 6};
    bit          m_zr   [2] = '{1'b0, 1'b1};
    int          checks   = 0;
    int          failures = 0;
    int          txn      = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit readable(input int d, input logic [2:0] n);
        return (int'(n) < m_regn[d]) && !(m_zr[d] && n == 3'd0);
    endfunction

    function automatic logic [15:0] opsel(input int d, input logic [2:0] n);
        if (!readable(d, n))         return 16'h0000;
        if (wb_en && n_wb == n)      return wb_data;
        return mregs[d][n];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 8; r++) mregs[d][r] = 16'h0000;
            mout[d] = '{dut: d, valid: 1'b0, rs: 16'h0, rt: 16'h0, nrs: 3'd0, nrt: 3'd0, nrd: 3'd0};
        end
    endtask

    // Predict the next pipeline register from the current inputs, then
    // apply the write so the next prediction sees the updated file.
    task automatic model_step(input int d);
        exp_t o;
        o = mout[d];
        o.dut = d;
        if (flush) begin
            o.valid = 1'b0;
        end else if (stall) begin
            if (o.valid && wb_en && n_wb == o.nrs) o.rs = readable(d, o.nrs) ? wb_data : 16'h0;
            if (o.valid && wb_en && n_wb == o.nrt) o.rt = readable(d, o.nrt) ? wb_data : 16'h0;
        end else if (in_valid) begin
            o.valid = 1'b1;
            o.rs  = opsel(d, n_rs_in);
            o.rt  = opsel(d, n_rt_in);
            o.nrs = n_rs_in;
            o.nrt = n_rt_in;
            o.nrd = n_rd_in;
        end else begin
            o.valid = 1'b0;
        end
        if (wb_en && readable(d, n_wb)) mregs[d][n_wb] = wb_data;
        mout[d] = o;
        sb_q.push_back(o);
    endtask

    task automatic compare_dut(input exp_t e);
        logic        g_valid;
        logic [15:0] g_rs, g_rt;
        logic [2:0]  g_nrs, g_nrt, g_nrd;
        string       p;
        if (e.dut == 0) begin
            p = "a";
            g_valid = bus_a.out_valid; g_rs = bus_a.rs_out; g_rt = bus_a.rt_out;
            g_nrs = bus_a.n_rs_out; g_nrt = bus_a.n_rt_out; g_nrd = bus_a.n_rd_out;
        end else begin
            p = "b";
            g_valid = bus_b.out_valid; g_rs = bus_b.rs_out; g_rt = bus_b.rt_out;
            g_nrs = bus_b.n_rs_out; g_nrt = bus_b.n_rt_out; g_nrd = bus_b.n_rd_out;
        end
        check_val({p, "_valid"}, 32'(g_valid), 32'(e.valid));
        check_val({p, "_rs"},    32'(g_rs),    32'(e.rs));
        check_val({p, "_rt"},    32'(g_rt),    32'(e.rt));
        check_val({p, "_nrs"},   32'(g_nrs),   32'(e.nrs));
        check_val({p, "_nrt"},   32'(g_nrt),   32'(e.nrt));
        check_val({p, "_nrd"},   32'(g_nrd),   32'(e.nrd));
    endtask

    // One clock of traffic: predict, clock, then score both instances.
    task automatic step();
        exp_t e;
        model_step(0);
        model_step(1);
        @(posedge clk_dc);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_val("sb_depth", 32'(sb_q.size()), 32'(2 - k));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                compare_dut(e);
            end
        end
        txn++;
        $display("txn %0d: v=%b rs=%0d rt=%0d rd=%0d st=%b fl=%b wb=%b/%0d/%h -> a: v=%b rs=%h rt=%h rd=%0d  b: v=%b rs=%h rt=%h",
                 txn, in_valid, n_rs_in, n_rt_in, n_rd_in, stall, flush, wb_en, n_wb, wb_data,
                 bus_a.out_valid, bus_a.rs_out, bus_a.rt_out, bus_a.n_rd_out,
                 bus_b.out_valid, bus_b.rs_out, bus_b.rt_out);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_a_valid"}, 32'(bus_a.out_valid), 32'd0);
        check_val({tag, "_a_rs"},    32'(bus_a.rs_out),    32'd0);
        check_val({tag, "_a_rt"},    32'(bus_a.rt_out),    32'd0);
        check_val({tag, "_a_num"},   32'({bus_a.n_rs_out, bus_a.n_rt_out, bus_a.n_rd_out}), 32'd0);
        check_val({tag, "_b_valid"}, 32'(bus_b.out_valid), 32'd0);
        check_val({tag, "_b_rs"},    32'(bus_b.rs_out),    32'd0);
        check_val({tag, "_b_rt"},    32'(bus_b.rt_out),    32'd0);
        check_val({tag, "_b_num"},   32'({bus_b.n_rs_out, bus_b.n_rt_out, bus_b.n_rd_out}), 32'd0);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0; wb_en = 1'b0;
        n_rs_in = R0; n_rt_in = R0; n_rd_in = R0; n_wb = R0; wb_data = 16'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk_dc);
        #1;
        check_zero_outputs("reset");
        @(negedge clk_dc);
        rst = 1'b0;

        // Fill r1..r7 with 0x0011*k (dut_b drops r6/r7 writes).
        for (int k = 1; k <= 7; k++) begin
            idle_inputs();
            wb_en = 1'b1; n_wb = 3'(k); wb_data = 16'(16'h0011 * k);
            step();
        end

        // Plain read of r3/r5.
        idle_inputs();
        in_valid = 1'b1; n_rs_in = R3; n_rt_in = R5; n_rd_in = R1;
        step();
        check_val("t1_rs",    32'(bus_a.rs_out),    32'h0033);
        check_val("t1_rt",    32'(bus_a.rt_out),    32'h0055);
        check_val("t1_valid", 32'(bus_a.out_valid), 32'd1);

        // Same-cycle bypass; rt=6 is out of range on dut_b.
        in_valid = 1'b1; n_rs_in = R2; n_rt_in = R6; n_rd_in = R7;
        wb_en = 1'b1; n_wb = R2; wb_data = 16'hBEEF;
        step();
        check_val("t2_rs",   32'(bus_a.rs_out), 32'hBEEF);
        check_val("t2_a_rt", 32'(bus_a.rt_out), 32'h0066);
        check_val("t2_b_rt", 32'(bus_b.rt_out), 32'h0000);

        // Capture rt=r4, then stall 3 cycles with a write to r4 in the middle.
        idle_inputs();
        in_valid = 1'b1; n_rs_in = R1; n_rt_in = R4; n_rd_in = R5;
        step();
        stall = 1'b1; n_rs_in = R7; n_rt_in = R7; n_rd_in = R2;
        for (int c = 0; c < 3; c++) begin
            wb_en = (c == 1); n_wb = R4; wb_data = 16'h1234;
            step();
        end
        check_val("t3_rt",    32'(bus_a.rt_out),    32'h1234);
        check_val("t3_rd",    32'(bus_a.n_rd_out),  32'd5);
        check_val("t3_valid", 32'(bus_a.out_valid), 32'd1);

        // Flush wins over stall, then a bubble keeps valid low.
        wb_en = 1'b0; stall = 1'b1; flush = 1'b1;
        step();
        check_val("t4_flush", 32'(bus_a.out_valid), 32'd0);
        idle_inputs();
        step();
        check_val("t4_idle", 32'(bus_a.out_valid), 32'd0);

        // Write r0, then read r0 / r7.
        wb_en = 1'b1; n_wb = R0; wb_data = 16'hFFFF;
        step();
        idle_inputs();
        in_valid = 1'b1; n_rs_in = R0; n_rt_in = R7; n_rd_in = R3;
        step();
        check_val("t5_b_rs", 32'(bus_b.rs_out), 32'h0000);
        check_val("t5_b_rt", 32'(bus_b.rt_out), 32'h0000);
        check_val("t5_a_rs", 32'(bus_a.rs_out), 32'hFFFF);
        check_val("t5_a_rt", 32'(bus_a.rt_out), 32'h0077);

        // Mixed random traffic.
        for (int c = 0; c < 40; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            n_rs_in  = 3'($urandom_range(0, 7));
            n_rt_in  = ($urandom_range(0, 3) == 0) ? n_rs_in : 3'($urandom_range(0, 7));
            n_rd_in  = 3'($urandom_range(0, 7));
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            wb_en    = ($urandom_range(0, 1) == 1);
            n_wb     = 3'($urandom_range(0, 7));
            wb_data  = 16'($urandom);
            step();
        end

        // Asynchronous reset between edges, then re-read r3.
        idle_inputs();
        in_valid = 1'b1; n_rs_in = R3; n_rt_in = R2; n_rd_in = R4;
        wb_en = 1'b1; n_wb = R3; wb_data = 16'h5A5A;
        step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_zero_outputs("t6_async");
        idle_inputs();
        stall = 1'b1;
        @(negedge clk_dc);
        rst = 1'b0;
        // First edge after release is still stalled: nothing is captured.
        in_valid = 1'b1; n_rs_in = R3; n_rt_in = R3; n_rd_in = R6;
        step();
        stall = 1'b0;
        step();
        check_val("t6_rs",    32'(bus_a.rs_out),    32'h0000);
        check_val("t6_rt",    32'(bus_a.rt_out),    32'h0000);
        check_val("t6_valid", 32'(bus_a.out_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
